// File: rtl/max_min_scan_ctrl_if.sv
// Handshake bundle for max_min_scan_ctrl: start/busy control, sample stream in,
// result stream out.
interface max_min_scan_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
);
  logic             start;
  logic             busy;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] min_val;
  logic [IDXW-1:0]  max_idx;
  logic [IDXW-1:0]  min_idx;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  busy, in_ready, out_valid, max_val, min_val, max_idx, min_idx
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output busy, in_ready, out_valid, max_val, min_val, max_idx, min_idx
  );
endinterface

// File: rtl/max_min_scan_ctrl.sv
// Scans a frame of N unsigned samples with one comparator pair and reports
// max/min values plus the index of their first occurrence.
module max_min_scan_ctrl #(
  parameter int N     = 5,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  max_min_scan_ctrl_if.slave   bus
);
  localparam int IDXW = ($clog2(N) > 0) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t          state;
  logic [IDXW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      bus.busy      <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.max_val   <= '0;
      bus.min_val   <= '0;
      bus.max_idx   <= '0;
      bus.min_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= LOAD;
            count        <= '0;
            bus.busy     <= 1'b1;
            bus.in_ready <= 1'b1;
          end
        end

        LOAD: begin
          if (bus.in_valid) begin
            // First sample seeds both trackers; later ones use strict compares
            // so ties keep the earlier index.
            if (count == '0) begin
              bus.max_val <= bus.in_data;
              bus.min_val <= bus.in_data;
              bus.max_idx <= '0;
              bus.min_idx <= '0;
            end else begin
              if (bus.in_data > bus.max_val) begin
                bus.max_val <= bus.in_data;
                bus.max_idx <= count;
              end
              if (bus.in_data < bus.min_val) begin
                bus.min_val <= bus.in_data;
                bus.min_idx <= count;
              end
            end

            if (count == LAST) begin
              count         <= '0;
              state         <= DONE;
              bus.in_ready  <= 1'b0;
              bus.out_valid <= 1'b1;
            end else begin
              count <= count + IDXW'(1);
            end
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (bus.start) begin
              state        <= LOAD;
              count        <= '0;
              bus.in_ready <= 1'b1;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
        end

        default: begin
          state         <= IDLE;
          count         <= '0;
          bus.busy      <= 1'b0;
          bus.in_ready  <= 1'b0;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
